// File: rtl/mac_share_sequencer_if.sv
// Bus between the neuron request lines / downstream sink and the shared MAC sequencer.
//   req        : level request per neuron, held until its done pulse
//   out_ready  : downstream can accept the finished result
//   gnt        : one-hot grant, held for the whole operation
//   gnt_id     : binary index of the current grant
//   addr       : word select for the shared select block
//   mac_en     : accumulate the product at addr this cycle
//   mac_clr    : accumulator loads instead of adds (first word)
//   mac_last   : final word of the dot product
//   done       : one-cycle pulse to the finished requester
//   busy       : sequencer is not idle
// master = requesters/downstream side, slave = sequencer side.
interface mac_share_sequencer_if #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned WEIGHT_N = 5
);
    localparam int unsigned ADDR_W = (WEIGHT_N > 1) ? $clog2(WEIGHT_N) : 1;
    localparam int unsigned ID_W   = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic               out_ready;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic [ADDR_W-1:0]  addr;
    logic               mac_en;
    logic               mac_clr;
    logic               mac_last;
    logic [NUM_REQ-1:0] done;
    logic               busy;

    modport master (
        output req,
        output out_ready,
        input  gnt,
        input  gnt_id,
        input  addr,
        input  mac_en,
        input  mac_clr,
        input  mac_last,
        input  done,
        input  busy
    );

    modport slave (
        input  req,
        input  out_ready,
        output gnt,
        output gnt_id,
        output addr,
        output mac_en,
        output mac_clr,
        output mac_last,
        output done,
        output busy
    );
endinterface

// File: rtl/mac_share_sequencer.sv
// Shares one serial MAC datapath (WEIGHT_N-word dot product) between NUM_REQ neurons.
// Grants one requester at a time, steps the word address, drives MAC enable/clear/last,
// waits for downstream ready and then pulses done to the finished requester.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mac_share_sequencer_if.slave (req/out_ready in; gnt, gnt_id, addr,
//            mac_en, mac_clr, mac_last, done, busy out -- all registered)
// Build option:
//   FIXED_PRIORITY_EN defined   -> lowest eligible index wins, no rotating pointer
//   FIXED_PRIORITY_EN undefined -> round-robin starting after the last finished grant
module mac_share_sequencer #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned WEIGHT_N = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mac_share_sequencer_if.slave bus
);
    localparam int unsigned ADDR_W = (WEIGHT_N > 1) ? $clog2(WEIGHT_N) : 1;
    localparam int unsigned ID_W   = $clog2(NUM_REQ);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WEIGHT_N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               mac_en_q, mac_en_d;
    logic               mac_clr_q, mac_clr_d;
    logic               mac_last_q, mac_last_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] eligible;
    logic               win_valid;
    logic [ID_W-1:0]    win_id;
    logic [ADDR_W-1:0]  addr_nxt;

`ifndef FIXED_PRIORITY_EN
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    cand;
`endif

    // Winner selection; the requester whose done is showing is masked so its stale level
    // cannot win again in the same IDLE cycle.
    always_comb begin
        eligible  = bus.req & ~done_q;
        win_valid = 1'b0;
        win_id    = '0;
`ifdef FIXED_PRIORITY_EN
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!win_valid && eligible[ID_W'(k)]) begin
                win_valid = 1'b1;
                win_id    = ID_W'(k);
            end
        end
`else
        cand = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!win_valid && eligible[cand]) begin
                win_valid = 1'b1;
                win_id    = cand;
            end
        end
`endif
    end

    assign addr_nxt = addr_q + ADDR_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        addr_d     = addr_q;
        mac_en_d   = 1'b0;
        mac_clr_d  = 1'b0;
        mac_last_d = 1'b0;
        done_d     = '0;
`ifndef FIXED_PRIORITY_EN
        rr_ptr_d   = rr_ptr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d    = ST_RUN;
                    gnt_d      = NUM_REQ'(1) << win_id;
                    gnt_id_d   = win_id;
                    addr_d     = '0;
                    mac_en_d   = 1'b1;
                    mac_clr_d  = 1'b1;
                    mac_last_d = (LAST_ADDR == '0);
                end
            end
            ST_RUN: begin
                // Last word is on the bus this cycle: stop and hold addr.
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_WAIT;
                end else begin
                    addr_d     = addr_nxt;
                    mac_en_d   = 1'b1;
                    mac_last_d = (addr_nxt == LAST_ADDR);
                end
            end
            ST_WAIT: begin
                if (bus.out_ready) begin
                    state_d  = ST_IDLE;
                    done_d   = NUM_REQ'(1) << gnt_id_q;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    addr_d   = '0;
`ifndef FIXED_PRIORITY_EN
                    rr_ptr_d = gnt_id_q;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            addr_q     <= '0;
            mac_en_q   <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_last_q <= 1'b0;
            done_q     <= '0;
            busy_q     <= 1'b0;
`ifndef FIXED_PRIORITY_EN
            rr_ptr_q   <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            addr_q     <= addr_d;
            mac_en_q   <= mac_en_d;
            mac_clr_q  <= mac_clr_d;
            mac_last_q <= mac_last_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
`ifndef FIXED_PRIORITY_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.gnt_id   = gnt_id_q;
    assign bus.addr     = addr_q;
    assign bus.mac_en   = mac_en_q;
    assign bus.mac_clr  = mac_clr_q;
    assign bus.mac_last = mac_last_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_mac_share_sequencer.sv
// Self-checking bench for mac_share_sequencer: directed scenarios plus randomized
// requests checked against a transaction-level reference model (owner + word offset).
module tb_mac_share_sequencer;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned WEIGHT_N = 5;
    localparam int NR = 4;
    localparam int WN = 5;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mac_share_sequencer_if #(.NUM_REQ(NUM_REQ), .WEIGHT_N(WEIGHT_N)) bus ();
    mac_share_sequencer #(.NUM_REQ(NUM_REQ), .WEIGHT_N(WEIGHT_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mac_share_sequencer_if #(.NUM_REQ(NUM_REQ), .WEIGHT_N(1)) bus1 ();
    mac_share_sequencer #(.NUM_REQ(NUM_REQ), .WEIGHT_N(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the MAC, how many cycles since its first word, which done shows.
    int m_owner;
    int m_off;
    int m_done;
    int m_ptr;

    task automatic model_reset();
        m_owner = -1;
        m_off   = 0;
        m_done  = -1;
        m_ptr   = NR - 1;
    endtask

    function automatic int pick(input logic [3:0] r);
        int rv;
        rv = int'(r);
`ifdef FIXED_PRIORITY_EN
        for (int i = 0; i < NR; i++)
            if (((rv >> i) & 1) != 0 && i != m_done) return i;
`else
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (m_ptr + k) % NR;
            if (((rv >> i) & 1) != 0 && i != m_done) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_edge(input logic [3:0] r, input logic rdy);
        int nd;
        nd = -1;
        if (m_owner < 0) begin
            int w;
            w = pick(r);
            if (w >= 0) begin
                m_owner = w;
                m_off   = 0;
            end
        end else if (m_off < WN) begin
            m_off++;
        end else if (rdy) begin
            nd      = m_owner;
            m_ptr   = m_owner;
            m_owner = -1;
        end
        m_done = nd;
    endtask

    task automatic check_outputs();
        bit eb;
        bit een;
        int ea;
        eb  = (m_owner >= 0);
        een = eb && (m_off < WN);
        ea  = (m_off < WN) ? m_off : WN - 1;
        check("busy", 32'(bus.busy), 32'(eb));
        check("gnt", 32'(bus.gnt), eb ? (32'(1) << m_owner) : 32'(0));
        check("mac_en", 32'(bus.mac_en), 32'(een));
        check("mac_clr", 32'(bus.mac_clr), 32'(een && m_off == 0));
        check("mac_last", 32'(bus.mac_last), 32'(een && m_off == WN - 1));
        check("done", 32'(bus.done), (m_done >= 0) ? (32'(1) << m_done) : 32'(0));
        if (eb) begin
            check("gnt_id", 32'(bus.gnt_id), 32'(m_owner));
            check("addr", 32'(bus.addr), 32'(ea));
        end
    endtask

    task automatic check_zero_main(input string tag);
        check({tag, "_gnt"}, 32'(bus.gnt), 32'(0));
        check({tag, "_gnt_id"}, 32'(bus.gnt_id), 32'(0));
        check({tag, "_addr"}, 32'(bus.addr), 32'(0));
        check({tag, "_ctl"}, 32'({bus.mac_en, bus.mac_clr, bus.mac_last, bus.busy}), 32'(0));
        check({tag, "_done"}, 32'(bus.done), 32'(0));
    endtask

    // One clock: drive inputs, advance model at the edge, compare just after it.
    task automatic cycle(input logic [3:0] r, input logic rdy);
        bus.req       = r;
        bus.out_ready = rdy;
        @(posedge clk);
        model_edge(r, rdy);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req = '0;
        bus.out_ready = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int n_en, first_en, done_at, done_val, n_grants, n_done1;
    int got_order[5];
    int exp_order[5];
    logic [3:0] rq, nxt, bitm;
    logic [3:0] e1_gnt[6];
    logic [3:0] e1_done[6];
    logic       e1_en[6];

    initial begin
        rst_n = 1'b0;
        bus.req = '0;
        bus.out_ready = 1'b0;
        bus1.req = '0;
        bus1.out_ready = 1'b0;
        model_reset();
        #12;
        check_zero_main("rst");
        check("rst1_all", 32'({bus1.gnt, bus1.done, bus1.mac_en, bus1.mac_clr,
                               bus1.mac_last, bus1.busy}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, ready high: 5 words, one WAIT cycle, then done; stale level masked.
        n_en = 0; first_en = -1; done_at = -1; done_val = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(4'b0001, 1'b1);
            if (bus.mac_en) begin
                n_en++;
                if (first_en < 0) first_en = i;
            end
            if (bus.done != 0) begin
                done_at = i;
                done_val = int'(bus.done);
            end
            if (i == 7) check("t1_mask_idle", 32'(bus.busy), 32'(0));
        end
        check("t1_n_en", 32'(n_en), 32'(WN));
        check("t1_latency", 32'(done_at - first_en), 32'(WN + 1));
        check("t1_done_val", 32'(done_val), 32'(4'b0001));

        // All requesting: rotation through every requester.
        do_reset();
        n_grants = 0;
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(4'b1111, 1'b1);
            check("t2_onehot", 32'($onehot0(bus.gnt)), 32'(1));
            if (bus.mac_clr && n_grants < 5) begin
                got_order[n_grants] = int'(bus.gnt_id);
                n_grants++;
            end
        end
        check("t2_n_grants", 32'(n_grants), 32'(5));
`ifndef FIXED_PRIORITY_EN
        for (int j = 0; j < 5; j++) check("t2_order", 32'(got_order[j]), 32'(exp_order[j]));
`endif

        // Downstream stalls for 10 cycles after the last word.
        do_reset();
        for (int i = 0; i < 15; i++) cycle(4'b0100, 1'b0);
        check("t3_wait_gnt", 32'(bus.gnt), 32'(4'b0100));
        check("t3_wait_nodone", 32'(bus.done), 32'(0));
        check("t3_wait_busy", 32'(bus.busy), 32'(1));
        cycle(4'b0100, 1'b1);
        check("t3_done", 32'(bus.done), 32'(4'b0100));

        // Asynchronous reset in the middle of a run.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(4'b0010, 1'b1);
        check("t4_addr2", 32'(bus.addr), 32'(2));
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_zero_main("t4_async");
        @(posedge clk);
        #1;
        check_zero_main("t4_held");
        @(negedge clk);
        rst_n = 1'b1;
        n_en = 0;
        for (int i = 0; i < 7; i++) begin
            cycle(4'b0010, 1'b1);
            if (bus.mac_en) n_en++;
        end
        check("t4_n_en", 32'(n_en), 32'(WN));

        // Granted request dropped mid-run still completes.
        do_reset();
        n_done1 = 0;
        cycle(4'b0010, 1'b1);
        cycle(4'b0010, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cycle(4'b0000, 1'b1);
            if (bus.done == 4'b0010) n_done1++;
        end
        check("t6_done_once", 32'(n_done1), 32'(1));
        check("t6_idle", 32'(bus.busy), 32'(0));

        // WEIGHT_N = 1 instance: single-word runs, done order 0 then 1.
        do_reset();
        e1_gnt[0] = 4'b0001; e1_en[0] = 1'b1; e1_done[0] = 4'b0000;
        e1_gnt[1] = 4'b0001; e1_en[1] = 1'b0; e1_done[1] = 4'b0000;
        e1_gnt[2] = 4'b0000; e1_en[2] = 1'b0; e1_done[2] = 4'b0001;
        e1_gnt[3] = 4'b0010; e1_en[3] = 1'b1; e1_done[3] = 4'b0000;
        e1_gnt[4] = 4'b0010; e1_en[4] = 1'b0; e1_done[4] = 4'b0000;
        e1_gnt[5] = 4'b0000; e1_en[5] = 1'b0; e1_done[5] = 4'b0010;
        bus1.req = 4'b0011;
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("w1_gnt", 32'(bus1.gnt), 32'(e1_gnt[i]));
            check("w1_en", 32'(bus1.mac_en), 32'(e1_en[i]));
            check("w1_clr", 32'(bus1.mac_clr), 32'(e1_en[i]));
            check("w1_last", 32'(bus1.mac_last), 32'(e1_en[i]));
            check("w1_done", 32'(bus1.done), 32'(e1_done[i]));
            check("w1_addr", 32'(bus1.addr), 32'(0));
        end
        bus1.req = '0;

        // Randomized traffic with occasional drops, stalls and mid-run resets.
        do_reset();
        rq = '0;
        for (int c = 0; c < 3000; c++) begin
            nxt = rq;
            for (int i = 0; i < NR; i++) begin
                bitm = 4'(1 << i);
                if ((rq & bitm) == 0) begin
                    if ($urandom_range(3) == 0) nxt = nxt | bitm;
                end else if (m_done == i) begin
                    if ($urandom_range(1) == 0) nxt = nxt & ~bitm;
                end else if (m_owner == i) begin
                    if ($urandom_range(15) == 0) nxt = nxt & ~bitm;
                end
            end
            rq = nxt;
            cycle(rq, ($urandom_range(2) != 0) ? 1'b1 : 1'b0);
            check("rnd_onehot", 32'($onehot0(bus.gnt)), 32'(1));
            if ($urandom_range(399) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_zero_main("rnd_rst");
                @(negedge clk);
                rst_n = 1'b1;
                rq = '0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
